// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, fetch state encoding and instruction field positions.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchState_t;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts unacknowledged bus cycles and flags a timeout.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  assign expired = busy && !ack && count == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    count <= (!rst_n || !busy || ack || expired) ? '0 : count + 1'b1;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, imem req/ack fetch and decode handoff with redirect squash.
// Optional bus timeout fault when FETCH_TIMEOUT_EN is defined.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  OPCode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);
  fetchState_t state, nextState;
  logic [31:0] pc, pcNext, addrReg;
  logic timeout, fetchErr, canFetch, take, holdAddr;
  assign canFetch = fetch_en & ~fetchErr;
  assign take = state == REQ && imem_ack && !redirect;
  assign imem_req = state == REQ || state == DRAIN;
  // the bus address must not move until the outstanding request is acked
  assign holdAddr = imem_req && !imem_ack && nextState != IDLE;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  nextState = (canFetch && !redirect) ? REQ : IDLE;
      REQ:   nextState = imem_ack ? (redirect ? (canFetch ? REQ : IDLE) : HOLD)
                       : redirect ? DRAIN : timeout ? IDLE : REQ;
      HOLD:  nextState = (redirect || instr_ready) ? (canFetch ? REQ : IDLE) : HOLD;
      DRAIN: nextState = imem_ack ? (canFetch ? REQ : IDLE)
                       : (timeout && !redirect) ? IDLE : DRAIN;
      default: nextState = IDLE;
    endcase
    pcNext = redirect ? {redirect_pc[31:2], 2'b00} : take ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC & ~32'h3;
      addrReg     <= RESET_PC & ~32'h3;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
    end else begin
      state       <= nextState;
      pc          <= pcNext;
      addrReg     <= holdAddr ? addrReg : pcNext;
      instr_valid <= nextState == HOLD;
      if (take) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
    end
  end
  assign imem_addr = addrReg;
  assign OPCode    = instr[OPC_MSB:OPC_LSB];
  assign pc_plus4  = pc_out + 32'd4;
`ifdef FETCH_TIMEOUT_EN
  fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) timer (
    .clk(clk), .rst_n(rst_n), .busy(imem_req), .ack(imem_ack), .expired(timeout)
  );
  always_ff @(posedge clk)
    fetchErr <= (!rst_n || redirect) ? 1'b0 : timeout ? 1'b1 : fetchErr;
`else
  assign timeout  = 1'b0;
  assign fetchErr = 1'b0;
`endif
  assign fetch_err = fetchErr;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus random traffic against a transaction-level model.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int TMO = 16;
  logic clk = 0, rst_n = 0, fetch_en = 0, imem_ack = 0, instr_ready = 0, redirect = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4;
  logic [5:0] OPCode;
  int nChecks = 0, nErrors = 0;
  bit mBusy, mSquash, mValid, mErr;
  logic [31:0] mPc, mAddr, mInstr, mPcOut;
  int mWait;

  instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .OPCode(OPCode), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One outstanding request, one held instruction, and a discard flag for squashed requests.
  task automatic modelStep();
    bit idle, busyN, validN, errN, squashN, timedOut;
    logic [31:0] pcN;
    int waitN;
    if (!rst_n) begin
      mBusy = 0; mSquash = 0; mValid = 0; mErr = 0;
      mPc = RST_PC; mAddr = RST_PC; mInstr = 0; mPcOut = 0; mWait = 0;
      return;
    end
    idle = !mBusy && !mValid;
    busyN = mBusy; validN = mValid; errN = mErr; squashN = mSquash; pcN = mPc; waitN = mWait;
    timedOut = 0;
`ifdef FETCH_TIMEOUT_EN
    timedOut = mBusy && !imem_ack && mWait == TMO - 1;
`endif
    if (mBusy) begin
      if (imem_ack) begin
        if (!mSquash && !redirect) begin
          validN = 1; mInstr = imem_rdata; mPcOut = mAddr; pcN = mPc + 4;
        end
        busyN = 0; squashN = 0; waitN = 0;
      end else if (redirect) begin
        squashN = 1; waitN = timedOut ? 0 : mWait + 1;
      end else if (timedOut) begin
        busyN = 0; errN = 1; squashN = 0; waitN = 0;
      end else waitN = mWait + 1;
    end
    if (redirect) begin
      pcN = redirect_pc & ~32'h3; validN = 0; errN = 0;
    end else if (mValid && instr_ready) validN = 0;
    if (!busyN && !validN && fetch_en && !errN && !(idle && redirect)) begin
      busyN = 1; mAddr = pcN; squashN = 0; waitN = 0;
    end
    mBusy = busyN; mValid = validN; mErr = errN; mSquash = squashN; mPc = pcN; mWait = waitN;
  endtask

  task automatic cyc();
    modelStep();
    @(posedge clk);
    #1;
    check("imem_req", 32'(imem_req), 32'(mBusy));
    check("imem_addr", imem_addr, mBusy ? mAddr : mPc);
    check("instr_valid", 32'(instr_valid), 32'(mValid));
    check("instr", instr, mInstr);
    check("OPCode", 32'(OPCode), 32'(mInstr[31:26]));
    check("pc_out", pc_out, mPcOut);
    check("pc_plus4", pc_plus4, mPcOut + 32'd4);
    check("fetch_err", 32'(fetch_err), 32'(mErr));
  endtask

  initial begin
    cyc(); cyc();
    check("rst_pc_plus4", pc_plus4, 32'd4);
    check("rst_addr", imem_addr, RST_PC);
    // back-to-back fetch with immediate ack
    rst_n = 1; fetch_en = 1; imem_ack = 1; instr_ready = 1; imem_rdata = 32'h8C01_0004;
    cyc(); check("seq_addr0", imem_addr, 32'h0);
    cyc(); check("seq_opcode", 32'(OPCode), 32'(6'b100011)); check("seq_valid", 32'(instr_valid), 1);
    cyc(); check("seq_addr4", imem_addr, 32'h4);
    cyc();
    cyc(); check("seq_addr8", imem_addr, 32'h8);
    // slow memory and slow decode
    imem_ack = 0; instr_ready = 0; imem_rdata = 32'h0123_4567;
    repeat (3) cyc();
    imem_ack = 1; cyc(); imem_ack = 0;
    repeat (4) cyc();
    check("hold_pc", pc_out, 32'h8);
    instr_ready = 1; cyc(); instr_ready = 0;
    // redirect while waiting on memory
    redirect = 1; redirect_pc = 32'h0000_0042; cyc(); redirect = 0;
    cyc(); check("drain_addr", imem_addr, 32'hC);
    imem_ack = 1; cyc(); imem_ack = 0;
    check("redir_addr", imem_addr, 32'h40); check("no_stale", 32'(instr_valid), 0);
    // PC wrap
    redirect = 1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1; cyc(); redirect = 0;
    cyc(); check("wrap_pc", pc_out, 32'hFFFF_FFFC); check("wrap_plus4", pc_plus4, 32'h0);
    imem_ack = 0; instr_ready = 1; cyc(); check("wrap_addr", imem_addr, 32'h0);
    // reset mid-request
    rst_n = 0; cyc();
    check("midrst_req", 32'(imem_req), 0); check("midrst_addr", imem_addr, RST_PC);
    rst_n = 1;
`ifdef FETCH_TIMEOUT_EN
    imem_ack = 0; fetch_en = 1; cyc();
    repeat (TMO) cyc();
    check("tmo_err", 32'(fetch_err), 1); check("tmo_req", 32'(imem_req), 0);
    redirect = 1; redirect_pc = 32'h100; cyc(); redirect = 0;
    check("tmo_clear", 32'(fetch_err), 0);
    cyc(); check("tmo_resume", imem_addr, 32'h100);
`endif
    for (int i = 0; i < 3000; i++) begin
      rst_n       = $urandom_range(99) >= 1;
      fetch_en    = $urandom_range(99) < 80;
      imem_ack    = $urandom_range(99) < 50;
      instr_ready = $urandom_range(99) < 60;
      redirect    = $urandom_range(99) < 6;
      imem_rdata  = $urandom;
      redirect_pc = $urandom;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
